// File: rtl/apb_uart_fifo.sv
// APB-attached full-duplex UART: TX/RX FIFOs, 16x oversampling baud generator,
// parity generation/checking, W1C sticky error flags and a maskable interrupt.
`timescale 1ns/1ps

module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         pclk,
  input  logic         preset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge pclk)
    if (do_push) mem[wp] <= wdata;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module apb_uart_fifo #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd1
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic [3:0] paddr,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  typedef struct packed {
    logic       stop2;
    logic       odd;
    logic       pen;
    logic [1:0] nbits;
  } cfg_t;

  localparam logic [3:0] A_CFG = 4'h0, A_DLO = 4'h1, A_DHI = 4'h2, A_TX = 4'h3,
                         A_RX  = 4'h4, A_ST  = 4'h5, A_IER = 4'h6;
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PAR  = 3'd3, S_STOP  = 3'd4;

  function automatic logic [7:0] nmask(input logic [1:0] nb);
    case (nb)
      2'd0:    nmask = 8'h1F;
      2'd1:    nmask = 8'h3F;
      2'd2:    nmask = 8'h7F;
      default: nmask = 8'hFF;
    endcase
  endfunction

  cfg_t        cfg;
  logic [15:0] div;
  logic [2:0]  ier;
  logic [2:0]  sticky;   // {frame, parity, overrun}
  logic [2:0]  err_set;
  logic        access, wr, rd, div_wr, err;
  logic [7:0]  rdata, status;

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;

  assign access = psel & penable;
  assign wr     = access & pwrite;
  assign rd     = access & ~pwrite;
  assign div_wr = wr & ((paddr == A_DLO) | (paddr == A_DHI));

  // ---------------- TX path ----------------
  logic [2:0]  tx_st, tx_bidx;
  logic [15:0] tx_pre;
  logic [3:0]  tx_tcnt;
  logic [7:0]  tx_sh;
  cfg_t        tx_cfg;
  logic        tx_stopn, tx_tick, tx_bit_end, tx_stop_last;
  logic [2:0]  tx_last;

  assign tx_tick      = (tx_pre == div);
  assign tx_bit_end   = tx_tick & (tx_tcnt == 4'd15);
  assign tx_stop_last = ~tx_cfg.stop2 | tx_stopn;
  assign tx_last      = 3'd4 + {1'b0, tx_cfg.nbits};
  // Reload straight from STOP so back-to-back frames have no idle gap.
  assign tx_pop  = ~tx_empty & ((tx_st == S_IDLE) |
                   ((tx_st == S_STOP) & tx_bit_end & tx_stop_last));
  assign tx_push = wr & (paddr == A_TX) & ~tx_full;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .pclk(pclk), .preset_n(preset_n), .push(tx_push), .wdata(pwdata),
    .pop(tx_pop), .rdata(tx_head), .empty(tx_empty), .full(tx_full));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tx_st    <= S_IDLE;
      tx_pre   <= '0;
      tx_tcnt  <= '0;
      tx_bidx  <= '0;
      tx_sh    <= '0;
      tx_cfg   <= '0;
      tx_stopn <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      if (tx_st == S_IDLE || div_wr) tx_pre <= '0;
      else                           tx_pre <= tx_tick ? 16'd0 : tx_pre + 16'd1;
      if (tx_tick && tx_st != S_IDLE) tx_tcnt <= tx_tcnt + 4'd1;
      case (tx_st)
        S_IDLE:  tx_tcnt <= '0;
        S_START: if (tx_bit_end) begin tx_st <= S_DATA; tx_bidx <= '0; end
        S_DATA:  if (tx_bit_end) begin
                   tx_stopn <= 1'b0;
                   if (tx_bidx == tx_last) tx_st <= tx_cfg.pen ? S_PAR : S_STOP;
                   else                    tx_bidx <= tx_bidx + 3'd1;
                 end
        S_PAR:   if (tx_bit_end) begin tx_st <= S_STOP; tx_stopn <= 1'b0; end
        S_STOP:  if (tx_bit_end) begin
                   if (!tx_stop_last)  tx_stopn <= 1'b1;
                   else if (tx_empty)  tx_st <= S_IDLE;
                 end
        default: tx_st <= S_IDLE;
      endcase
      if (tx_pop) begin
        tx_sh    <= tx_head & nmask(cfg.nbits);
        tx_cfg   <= cfg;
        tx_st    <= S_START;
        tx_stopn <= 1'b0;
      end
      case (tx_st)
        S_START: uart_tx <= 1'b0;
        S_DATA:  uart_tx <= tx_sh[tx_bidx];
        S_PAR:   uart_tx <= (^tx_sh) ^ tx_cfg.odd;
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic        rx_s1, rx_s2;
  logic [2:0]  rx_st, rx_bidx;
  logic [15:0] rx_pre;
  logic [3:0]  rx_tcnt;
  logic [7:0]  rx_sh;
  logic [1:0]  rx_nb;
  logic        rx_pen, rx_odd, rx_par, rx_tick, rx_bit_end, rx_stop_smp, rx_par_bad;
  logic [2:0]  rx_last;

  assign rx_tick     = (rx_pre == div);
  assign rx_bit_end  = rx_tick & (rx_tcnt == 4'd15);
  assign rx_last     = 3'd4 + {1'b0, rx_nb};
  assign rx_stop_smp = (rx_st == S_STOP) & rx_bit_end;
  assign rx_par_bad  = rx_pen & (rx_par != ((^rx_sh) ^ rx_odd));
  assign rx_push     = rx_stop_smp & rx_s2 & ~rx_full;
  assign rx_pop      = rd & (paddr == A_RX) & ~rx_empty;
  assign err_set     = {rx_stop_smp & ~rx_s2,
                        rx_stop_smp & rx_s2 & rx_par_bad,
                        rx_stop_smp & rx_s2 & rx_full};

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .pclk(pclk), .preset_n(preset_n), .push(rx_push), .wdata(rx_sh),
    .pop(rx_pop), .rdata(rx_head), .empty(rx_empty), .full(rx_full));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_st   <= S_IDLE;
      rx_pre  <= '0;
      rx_tcnt <= '0;
      rx_bidx <= '0;
      rx_sh   <= '0;
      rx_nb   <= '0;
      rx_pen  <= 1'b0;
      rx_odd  <= 1'b0;
      rx_par  <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      if (rx_st == S_IDLE || div_wr) rx_pre <= '0;
      else                           rx_pre <= rx_tick ? 16'd0 : rx_pre + 16'd1;
      if (rx_tick) rx_tcnt <= rx_tcnt + 4'd1;
      case (rx_st)
        S_IDLE:  if (!rx_s2) begin
                   rx_nb   <= cfg.nbits;
                   rx_pen  <= cfg.pen;
                   rx_odd  <= cfg.odd;
                   rx_tcnt <= '0;
                   rx_sh   <= '0;
                   rx_st   <= S_START;
                 end
        // Half a bit into the start bit: re-check the line to reject glitches.
        S_START: if (rx_tick && rx_tcnt == 4'd7) begin
                   rx_tcnt <= '0;
                   rx_bidx <= '0;
                   rx_st   <= rx_s2 ? S_IDLE : S_DATA;
                 end
        S_DATA:  if (rx_bit_end) begin
                   rx_sh[rx_bidx] <= rx_s2;
                   if (rx_bidx == rx_last) rx_st <= rx_pen ? S_PAR : S_STOP;
                   else                    rx_bidx <= rx_bidx + 3'd1;
                 end
        S_PAR:   if (rx_bit_end) begin rx_par <= rx_s2; rx_st <= S_STOP; end
        S_STOP:  if (rx_bit_end) rx_st <= S_IDLE;
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- Registers / APB ----------------
  assign status = {(tx_st != S_IDLE), sticky, rx_full, ~rx_empty, tx_full, tx_empty};

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cfg    <= '0;
      div    <= DEFAULT_DIV;
      ier    <= '0;
      sticky <= '0;
      irq    <= 1'b0;
      pready <= 1'b0;
    end else begin
      pready <= 1'b1;
      if (wr) begin
        case (paddr)
          A_CFG:   cfg        <= cfg_t'(pwdata[4:0]);
          A_DLO:   div[7:0]   <= pwdata;
          A_DHI:   div[15:8]  <= pwdata;
          A_IER:   ier        <= pwdata[2:0];
          default: ;
        endcase
      end
      // A new error event in the same cycle as a clear keeps the flag set.
      sticky <= (sticky & ~({3{wr & (paddr == A_ST)}} & pwdata[6:4])) | err_set;
      irq    <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty) | (ier[2] & (|sticky));
    end
  end

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (paddr)
      A_CFG: rdata = {3'b000, cfg};
      A_DLO: rdata = div[7:0];
      A_DHI: rdata = div[15:8];
      A_TX:  err   = pwrite & tx_full;
      A_RX:  begin
               rdata = rx_empty ? 8'h00 : rx_head;
               err   = ~pwrite & rx_empty;
             end
      A_ST:  rdata = status;
      A_IER: rdata = {5'b00000, ier};
      default: err = 1'b1;
    endcase
  end

  assign prdata  = rd ? rdata : 8'h00;
  assign pslverr = access & err;
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: scoreboard queues hold expected line bits
// and received bytes; every comparison is an immediate assertion.
`timescale 1ns/1ps

module tb_apb_uart_fifo;
  localparam int DEPTH = 16;
  localparam int BITC  = 48;   // cycles per bit at DIV=2
  localparam logic [3:0] A_CFG = 4'h0, A_DLO = 4'h1, A_DHI = 4'h2, A_TX = 4'h3,
                         A_RX  = 4'h4, A_ST  = 4'h5, A_IER = 4'h6;

  logic       pclk = 1'b0, preset_n = 1'b0;
  logic [3:0] paddr = '0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready, pslverr, uart_tx, irq, uart_rx;
  logic       rx_drv = 1'b1, loopback = 1'b0;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  apb_uart_fifo #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd1)) dut (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .irq(irq));

  always #5 pclk = ~pclk;

  int checks = 0, errors = 0;
  logic [7:0] rxq[$];
  logic       txq[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [7:0] d, output logic e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    e = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [7:0] d, output logic e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    d = prdata;
    e = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Cycles from the current point until uart_tx goes low (bounded).
  task automatic wait_fall(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge pclk); #1;
      n++;
      if (uart_tx === 1'b0) break;
    end
  endtask

  task automatic hold_bit(input int c);
    repeat (c) @(posedge pclk);
    #1;
  endtask

  // 8 data bits, odd parity (optionally inverted), stop optionally forced low.
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop_low);
    @(posedge pclk); #1;
    rx_drv = 1'b0; hold_bit(BITC);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; hold_bit(BITC); end
    rx_drv = (^b) ^ 1'b1 ^ flip; hold_bit(BITC);
    if (stop_low) begin rx_drv = 1'b0; hold_bit(36); end
    else          begin rx_drv = 1'b1; hold_bit(BITC); end
    rx_drv = 1'b1; hold_bit(BITC);
  endtask

  logic [7:0] d;
  logic       e;
  int         n;
  logic [7:0] tb_byte;
  logic [9:0] a5_bits;

  initial begin
    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready", pready, 1'b0);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_irq", irq, 1'b0);
    preset_n = 1'b1;
    @(posedge pclk); #1;
    chk("pready_up", pready, 1'b1);
    chk("prdata_idle", prdata, 8'h00);
    apb_read(A_ST, d, e);
    chk("rst_status", d, 8'h01);
    apb_read(A_DLO, d, e);
    chk("rst_div_lo", d, 8'h01);

    // TX 0xA5, 8N1 at DIV=0: 16 cycles per bit
    apb_write(A_DLO, 8'h00, e);
    apb_write(A_DHI, 8'h00, e);
    apb_write(A_CFG, 8'h03, e);
    a5_bits = 10'b1_10100101_0;
    for (int i = 0; i < 10; i++) txq.push_back(a5_bits[i]);
    apb_write(A_TX, 8'hA5, e);
    chk("tx_wr_err", e, 1'b0);
    wait_fall(n);
    chk("tx_latency", n[15:0], 16'd2);
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic bexp;
          bexp = txq.pop_front();
          for (int c = 0; c < 16; c++) begin
            @(negedge pclk);
            chk("tx_bit", uart_tx, bexp);
          end
        end
      end
      begin
        repeat (30) @(posedge pclk);
        apb_read(A_ST, d, e);
        chk("status_busy", d, 8'h81);
      end
    join
    repeat (3) @(posedge pclk);
    apb_read(A_ST, d, e);
    chk("status_tx_done", d, 8'h01);

    // Loopback, 8O1 at DIV=2
    apb_write(A_CFG, 8'h0F, e);
    apb_write(A_DLO, 8'h02, e);
    loopback = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tb_byte = (j == 0) ? 8'h00 : 8'h7F;
      rxq.push_back(tb_byte);
      apb_write(A_TX, tb_byte, e);
      wait_fall(n);
      chk("lb_latency", n[15:0], 16'd2);
      repeat (9 * BITC + 24) @(posedge pclk);
      #1;
      chk("lb_parity_bit", uart_tx, (^tb_byte) ^ 1'b1);
      repeat (2 * BITC + 40) @(posedge pclk);
    end
    for (int j = 0; j < 2; j++) begin
      apb_read(A_RX, d, e);
      chk("lb_rxdata", d, rxq.pop_front());
      chk("lb_rx_err", e, 1'b0);
    end
    apb_read(A_ST, d, e);
    chk("lb_status_clean", d, 8'h01);
    loopback = 1'b0;

    // Parity error (byte kept) then framing error (byte dropped)
    rxq.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    apb_read(A_ST, d, e);
    chk("err_status", d, 8'h65);
    apb_read(A_RX, d, e);
    chk("par_err_byte", d, rxq.pop_front());
    apb_read(A_ST, d, e);
    chk("err_status_empty", d, 8'h61);
    apb_write(A_ST, 8'h70, e);
    apb_read(A_ST, d, e);
    chk("err_cleared", d, 8'h01);

    // TX FIFO overflow with the transmitter stalled in a slow frame
    apb_write(A_DLO, 8'hFF, e);
    apb_write(A_DHI, 8'hFF, e);
    apb_write(A_TX, 8'h11, e);
    repeat (3) @(posedge pclk);
    for (int i = 0; i <= DEPTH; i++) begin
      apb_write(A_TX, 8'(i), e);
      chk("tx_push_err", e, (i == DEPTH) ? 1'b1 : 1'b0);
    end
    apb_read(A_ST, d, e);
    chk("tx_full_status", d, 8'h82);

    // Reset mid-frame
    @(posedge pclk); #1;
    preset_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("midrst_pready", pready, 1'b0);
    chk("midrst_uart_tx", uart_tx, 1'b1);
    chk("midrst_irq", irq, 1'b0);
    preset_n = 1'b1;
    @(posedge pclk); #1;
    apb_read(A_ST, d, e);
    chk("midrst_status", d, 8'h01);
    apb_read(A_DHI, d, e);
    chk("midrst_div_hi", d, 8'h00);
    apb_read(A_CFG, d, e);
    chk("midrst_cfg", d, 8'h00);

    // RX overrun: DEPTH+1 frames without reading
    apb_write(A_CFG, 8'h0F, e);
    apb_write(A_DLO, 8'h02, e);
    for (int i = 0; i <= DEPTH; i++) begin
      tb_byte = 8'(i * 13 + 5);
      if (i < DEPTH) rxq.push_back(tb_byte);
      send_frame(tb_byte, 1'b0, 1'b0);
    end
    apb_read(A_ST, d, e);
    chk("ovr_status", d, 8'h1D);
    for (int i = 0; i < DEPTH; i++) begin
      apb_read(A_RX, d, e);
      chk("ovr_rxdata", d, rxq.pop_front());
    end
    apb_read(A_ST, d, e);
    chk("ovr_status_empty", d, 8'h11);
    apb_write(A_ST, 8'h10, e);
    apb_read(A_ST, d, e);
    chk("ovr_cleared", d, 8'h01);

    // Interrupt on rx_nonempty: the stop mid-sample lands 507 cycles after the start edge
    apb_write(A_IER, 8'h01, e);
    @(posedge pclk); #1;
    chk("irq_idle", irq, 1'b0);
    rxq.push_back(8'hC3);
    fork
      send_frame(8'hC3, 1'b0, 1'b0);
      begin
        @(negedge rx_drv);
        repeat (507) @(posedge pclk);
        #1;
        chk("irq_before", irq, 1'b0);
        @(posedge pclk); #1;
        chk("irq_rise", irq, 1'b1);
      end
    join
    apb_read(A_RX, d, e);
    chk("irq_rxdata", d, rxq.pop_front());
    chk("irq_hold", irq, 1'b1);
    @(posedge pclk); #1;
    chk("irq_drop", irq, 1'b0);

    // Empty read and unmapped addresses
    apb_read(A_RX, d, e);
    chk("empty_rx_data", d, 8'h00);
    chk("empty_rx_err", e, 1'b1);
    apb_read(4'h9, d, e);
    chk("unmapped_rd_data", d, 8'h00);
    chk("unmapped_rd_err", e, 1'b1);
    apb_write(4'hF, 8'hAA, e);
    chk("unmapped_wr_err", e, 1'b1);
    apb_read(A_IER, d, e);
    chk("ier_readback", d, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
